norm_stream_pipe: RTL and testbench
===================================

Name: norm_stream_pipe

Overview:
- Successor to the single-lane frame normaliser. Sits between the crop-filter output and the downstream AXI-Stream FIFO / DMA path.
- Scales every pixel of a frame by (2^PIX_WIDTH-1)/denominator, with LANES pixels per beat.
- Derives the coefficient internally with a sequential divider, so no reciprocal LUT is needed.
- Frame size is set at run time, the output carries tlast, and the datapath is a pipeline with back-pressure.

Parameters:
- PIX_WIDTH, 8, bits per pixel (input and output).
- LANES, 1, pixels per AXI-Stream beat; lane i occupies tdata[i*PIX_WIDTH +: PIX_WIDTH].
- FRAC_WIDTH, 24, fractional bits of the coefficient.
- MAX_PIXELS, 16384, largest supported frame; sets the counter width to $clog2(MAX_PIXELS/LANES+1).

Ports:
- clk  in  1  clock
- srst  in  1  synchronous reset, active-high
- ap_start  in  1  start request; sampled only in IDLE
- ap_ready  out  1  high in IDLE
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse when the last output beat handshakes
- up_done  in  1  upstream crop-filter done pulse; level-captured
- frame_pixels  in  $clog2(MAX_PIXELS+1)  pixels per frame; latched on start; must be a nonzero multiple of LANES
- norm_denominator  in  PIX_WIDTH  divisor; latched on start
- err_div0  out  1  sticky flag: a frame was started with denominator 0
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat ready
- s_axis_tdata  in  LANES*PIX_WIDTH  input pixels
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  output beat ready
- m_axis_tdata  out  LANES*PIX_WIDTH  normalised pixels
- m_axis_tlast  out  1  high on the final beat of the frame

Behaviour:
- Reset values: all outputs 0 except ap_ready=1 and ap_idle=1. Reset state is IDLE; pipeline valids, counters, up_done capture and err_div0 are cleared. srst mid-frame aborts at once: no ap_done, and in-flight beats are dropped.
- States:
  - IDLE: ap_start=1 -> latch frame_pixels and norm_denominator, clear the up_done capture, go to DIV.
  - DIV: restoring divider computes coef = floor((2^PIX_WIDTH-1)*2^FRAC_WIDTH / denom), COEF_W = PIX_WIDTH+FRAC_WIDTH bits. Takes exactly COEF_W cycles, then goes to WAIT_UP. If denom=0: coef=0, err_div0 is set, and the divider is skipped (goes to WAIT_UP after 1 cycle).
  - WAIT_UP: go to RUN once the up_done capture is set. An up_done pulse arriving in DIV, or in the same cycle as ap_start, is still captured.
  - RUN: accept frame_pixels/LANES input beats. Go to IDLE in the cycle the last output beat handshakes, with ap_done=1 in that same cycle.
- ap_start outside IDLE is ignored.
- Per-lane arithmetic: out = min(2^PIX_WIDTH-1, (pix*coef + 2^(FRAC_WIDTH-1)) >> FRAC_WIDTH), i.e. round-half-up with saturation. Pixels greater than denom saturate to all-ones.
- Pipeline:
  - Stage 1 registers pix*coef. Stage 2 registers the rounded, saturated result plus tlast.
  - Latency is 2 cycles from input handshake to m_axis_tvalid when not stalled.
  - Global advance = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = (state==RUN) && (in_cnt < beats) && advance.
  - Full throughput of 1 beat/cycle.
- Handshake rules:
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast hold stable while tvalid=1 and tready=0.
  - No combinational path from m_axis_tready to m_axis_tvalid.
  - Input beats beyond the frame count are not accepted; s_axis_tready stays 0 until the next frame's RUN.
- Counters:
  - in_cnt counts input handshakes and out_cnt counts output handshakes; both clear on the IDLE->DIV transition.
  - tlast is attached to the input beat with in_cnt == beats-1.
- Single-beat frame (frame_pixels == LANES): tlast and ap_done occur on the first output beat.

Decomposition:
- Package norm_pkg holds:
  - the state enum typedef (IDLE, DIV, WAIT_UP, RUN);
  - the localparam function for COEF_W;
  - the rounding constant.
- Sub-module norm_lane_mult is instantiated LANES times. It contains the stage-1 multiply and the stage-2 round and saturate, with an advance enable.
- The divider, FSM and counters live in the top module.

Test Plan:
- PIX_WIDTH=8, LANES=1, denom=255, frame_pixels=4, up_done before start, pixels 0,1,200,255 -> outputs 0,1,200,255 (coef=2^24); tlast on the 4th beat; ap_done pulse on the same cycle.
- denom=128, pixel 64 -> 128 (127.5 rounds up); pixel 200 -> 255 (saturated); denom=100, pixel 99 -> 252.
- denom=0 -> err_div0=1 sticky; all outputs 0; frame still completes with tlast and ap_done.
- LANES=4, frame_pixels=8, random m_axis_tready at 50% -> exactly 2 beats with correct per-lane values; data stable under stall; no beat lost or duplicated.
- up_done delayed 50 cycles after start -> s_axis_tready stays 0 until the cycle after capture; ap_start pulsed during RUN is ignored.
- srst asserted mid-RUN with 2 beats in flight -> next cycle m_axis_tvalid=0, ap_ready=1, no ap_done; a new frame then runs correctly.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and helpers for the stream normaliser.
// Holds the FSM state enum, coefficient width and rounding constant.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        WAIT_UP,
        RUN
    } state_t;

    function automatic int coef_w(input int pix_w, input int frac_w);
        return pix_w + frac_w;
    endfunction

    function automatic logic [63:0] round_const(input int frac_w);
        return 64'(1) << (frac_w - 1);
    endfunction

endpackage

// File: rtl/norm_stream_pipe_lane.sv
// norm_lane_mult: one pixel lane, pix*coef then round-half-up + saturate.
// Ports: clk, srst, adv (pipeline enable), coef, pix in; res out (registered).
module norm_lane_mult
    import norm_pkg::*;
#(
    parameter int PIX_WIDTH  = 8,
    parameter int FRAC_WIDTH = 24
) (
    input  logic                                    clk,
    input  logic                                    srst,
    input  logic                                    adv,
    input  logic [coef_w(PIX_WIDTH, FRAC_WIDTH)-1:0] coef,
    input  logic [PIX_WIDTH-1:0]                    pix,
    output logic [PIX_WIDTH-1:0]                    res
);

    localparam int COEF_W = coef_w(PIX_WIDTH, FRAC_WIDTH);
    localparam int PROD_W = PIX_WIDTH + COEF_W;
    localparam logic [PROD_W:0] RND =
        (PROD_W + 1)'(round_const(FRAC_WIDTH));
    localparam logic [PROD_W:0] MAXV =
        {{(PROD_W + 1 - PIX_WIDTH){1'b0}}, {PIX_WIDTH{1'b1}}};

    logic [PROD_W-1:0] prod;
    logic [PROD_W:0]   sum;
    logic [PROD_W:0]   shf;

    // Extra top bit keeps the rounding add from wrapping.
    always_comb begin
        sum = {1'b0, prod} + RND;
        shf = sum >> FRAC_WIDTH;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            prod <= '0;
            res  <= '0;
        end else if (adv) begin
            prod <= PROD_W'(pix) * PROD_W'(coef);
            res  <= (shf > MAXV) ? '1 : shf[PIX_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/norm_stream_pipe.sv
// Frame normaliser: out = sat(round(pix*(2^PW-1)/denom)), LANES pixels/beat.
// Ports: ap_* control, up_done, frame_pixels, norm_denominator, err_div0,
// s_axis_* input stream, m_axis_* output stream with tlast.
module norm_stream_pipe
    import norm_pkg::*;
#(
    parameter int PIX_WIDTH  = 8,
    parameter int LANES      = 1,
    parameter int FRAC_WIDTH = 24,
    parameter int MAX_PIXELS = 16384
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic                            ap_start,
    output logic                            ap_ready,
    output logic                            ap_idle,
    output logic                            ap_done,
    input  logic                            up_done,
    input  logic [$clog2(MAX_PIXELS+1)-1:0] frame_pixels,
    input  logic [PIX_WIDTH-1:0]            norm_denominator,
    output logic                            err_div0,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [LANES*PIX_WIDTH-1:0]      s_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [LANES*PIX_WIDTH-1:0]      m_axis_tdata,
    output logic                            m_axis_tlast
);

    localparam int COEF_W = coef_w(PIX_WIDTH, FRAC_WIDTH);
    localparam int CNT_W  = $clog2(MAX_PIXELS / LANES + 1);
    localparam int DC_W   = $clog2(COEF_W + 1);
    localparam logic [COEF_W-1:0] DIVIDEND =
        {{PIX_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};

    state_t state, state_nx;

    logic [CNT_W-1:0]     beats_r, in_cnt, out_cnt;
    logic [PIX_WIDTH-1:0] den_r, rem;
    logic [COEF_W-1:0]    quo;
    logic [DC_W-1:0]      div_cnt;
    logic [PIX_WIDTH:0]   trial;
    logic up_cap, v1, last1, v2, last2;
    logic adv, in_hs, out_hs, last_out, start_go, div_end;

    assign start_go = (state == IDLE) && ap_start;
    assign div_end  = (state == DIV) &&
                      ((den_r == '0) || (div_cnt == DC_W'(COEF_W - 1)));
    assign adv      = !v2 || m_axis_tready;
    assign in_hs    = s_axis_tvalid && s_axis_tready;
    assign out_hs   = v2 && m_axis_tready;
    assign last_out = out_hs && (out_cnt == beats_r - CNT_W'(1));
    // Quotient register shifts out dividend bits as quotient bits shift in.
    assign trial    = {rem, quo[COEF_W-1]};

    assign ap_ready      = (state == IDLE);
    assign ap_idle       = (state == IDLE);
    assign ap_done       = last_out;
    assign s_axis_tready = (state == RUN) && (in_cnt < beats_r) && adv;
    assign m_axis_tvalid = v2;
    assign m_axis_tlast  = last2;

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ap_start) state_nx = DIV;
            DIV:     if (div_end)  state_nx = WAIT_UP;
            WAIT_UP: if (up_cap)   state_nx = RUN;
            RUN:     if (last_out) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            beats_r  <= '0;
            den_r    <= '0;
            rem      <= '0;
            quo      <= '0;
            div_cnt  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            up_cap   <= 1'b0;
            err_div0 <= 1'b0;
            v1       <= 1'b0;
            last1    <= 1'b0;
            v2       <= 1'b0;
            last2    <= 1'b0;
        end else begin
            // A pulse coinciding with start belongs to the new frame.
            up_cap <= start_go ? up_done : (up_cap | up_done);
            if (start_go) begin
                beats_r <= CNT_W'(frame_pixels / LANES);
                den_r   <= norm_denominator;
                rem     <= '0;
                quo     <= DIVIDEND;
                div_cnt <= '0;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            if (state == DIV) begin
                div_cnt <= div_cnt + DC_W'(1);
                if (den_r == '0) begin
                    quo      <= '0;
                    err_div0 <= 1'b1;
                end else if (trial >= {1'b0, den_r}) begin
                    rem <= trial[PIX_WIDTH-1:0] - den_r;
                    quo <= {quo[COEF_W-2:0], 1'b1};
                end else begin
                    rem <= trial[PIX_WIDTH-1:0];
                    quo <= {quo[COEF_W-2:0], 1'b0};
                end
            end
            if (in_hs)  in_cnt  <= in_cnt + CNT_W'(1);
            if (out_hs) out_cnt <= out_cnt + CNT_W'(1);
            if (adv) begin
                v1    <= in_hs;
                last1 <= in_hs && (in_cnt == beats_r - CNT_W'(1));
                v2    <= v1;
                last2 <= last1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        norm_lane_mult #(
            .PIX_WIDTH (PIX_WIDTH),
            .FRAC_WIDTH(FRAC_WIDTH)
        ) u_lane (
            .clk (clk),
            .srst(srst),
            .adv (adv),
            .coef(quo),
            .pix (s_axis_tdata[g*PIX_WIDTH +: PIX_WIDTH]),
            .res (m_axis_tdata[g*PIX_WIDTH +: PIX_WIDTH])
        );
    end

endmodule

// File: tb/tb_norm_stream_pipe.sv
// Directed bench for norm_stream_pipe: LANES=1 and LANES=4 instances.
// Hand-computed vectors checked with immediate assertions.
module tb_norm_stream_pipe;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    // LANES=1 instance
    logic        start1, ready1, idle1, done1, up1, err1;
    logic [14:0] fp1;
    logic [7:0]  den1;
    logic        s1_valid, s1_ready, m1_valid, m1_ready, m1_last;
    logic [7:0]  s1_data, m1_data;

    // LANES=4 instance
    logic        start4, ready4, idle4, done4, up4, err4;
    logic [14:0] fp4;
    logic [7:0]  den4;
    logic        s4_valid, s4_ready, m4_valid, m4_ready, m4_last;
    logic [31:0] s4_data, m4_data;

    norm_stream_pipe #(.PIX_WIDTH(8), .LANES(1)) dut1 (
        .clk(clk), .srst(srst),
        .ap_start(start1), .ap_ready(ready1), .ap_idle(idle1),
        .ap_done(done1), .up_done(up1), .frame_pixels(fp1),
        .norm_denominator(den1), .err_div0(err1),
        .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
        .s_axis_tdata(s1_data),
        .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
        .m_axis_tdata(m1_data), .m_axis_tlast(m1_last)
    );

    norm_stream_pipe #(.PIX_WIDTH(8), .LANES(4)) dut4 (
        .clk(clk), .srst(srst),
        .ap_start(start4), .ap_ready(ready4), .ap_idle(idle4),
        .ap_done(done4), .up_done(up4), .frame_pixels(fp4),
        .norm_denominator(den4), .err_div0(err4),
        .s_axis_tvalid(s4_valid), .s_axis_tready(s4_ready),
        .s_axis_tdata(s4_data),
        .m_axis_tvalid(m4_valid), .m_axis_tready(m4_ready),
        .m_axis_tdata(m4_data), .m_axis_tlast(m4_last)
    );

    int checks = 0;
    int errors = 0;

    // Output monitors (sampled on the falling edge)
    logic [8:0]  q1[$];
    logic [32:0] q4[$];
    int done_cnt1 = 0, done_cnt4 = 0;
    int dl_err1 = 0, dl_err4 = 0;
    int stab_err1 = 0, stab_err4 = 0;
    logic st1 = 0, st4 = 0, psr = 1;
    logic [7:0]  pd1;
    logic [31:0] pd4;
    logic pl1, pl4;

    always @(negedge clk) begin
        if (m1_valid && m1_ready) q1.push_back({m1_last, m1_data});
        if (m4_valid && m4_ready) q4.push_back({m4_last, m4_data});
        if (done1) done_cnt1++;
        if (done4) done_cnt4++;
        if (done1 !== (m1_valid && m1_ready && m1_last)) dl_err1++;
        if (done4 !== (m4_valid && m4_ready && m4_last)) dl_err4++;
        if (st1 && !psr &&
            (!m1_valid || m1_data !== pd1 || m1_last !== pl1)) stab_err1++;
        if (st4 && !psr &&
            (!m4_valid || m4_data !== pd4 || m4_last !== pl4)) stab_err4++;
        st1 = m1_valid && !m1_ready;
        st4 = m4_valid && !m4_ready;
        pd1 = m1_data; pl1 = m1_last;
        pd4 = m4_data; pl4 = m4_last;
        psr = srst;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick4();
        @(posedge clk);
        #1;
        m4_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic begin_frame1(input int n, input int den);
        fp1 = 15'(n);
        den1 = 8'(den);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        up1 = 1'b1;
        tick();
        up1 = 1'b0;
    endtask

    task automatic wait_ready1(input string tag);
        int n = 0;
        while (!s1_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(s1_ready), 64'd1);
    endtask

    task automatic send1(input logic [7:0] p);
        int n = 0;
        s1_valid = 1'b1;
        s1_data = p;
        while (!s1_ready && n < 100) begin
            tick();
            n++;
        end
        chk("send1_timeout", 64'(n < 100), 64'd1);
        tick();
        s1_valid = 1'b0;
    endtask

    task automatic wait_done1(input string tag, input int exp_cnt);
        int n = 0;
        while (done_cnt1 < exp_cnt && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt1), 64'(exp_cnt));
    endtask

    task automatic frame1(input string tag, input int den, input int n,
                          input logic [7:0] px[4], input logic [7:0] ex[4]);
        int d0;
        q1.delete();
        d0 = done_cnt1;
        begin_frame1(n, den);
        wait_ready1(tag);
        for (int i = 0; i < n; i++) send1(px[i]);
        wait_done1(tag, d0 + 1);
        tick();
        chk({tag, "_idle"}, 64'(idle1), 64'd1);
        chk({tag, "_beats"}, 64'(q1.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(q1[i]),
                64'({(i == n - 1) ? 1'b1 : 1'b0, ex[i]}));
    endtask

    initial begin
        int bad;
        int d0;
        int n;
        srst = 1'b1;
        start1 = 0; up1 = 0; fp1 = 0; den1 = 0;
        s1_valid = 0; s1_data = 0; m1_ready = 1;
        start4 = 0; up4 = 0; fp4 = 0; den4 = 0;
        s4_valid = 0; s4_data = 0; m4_ready = 1;
        repeat (3) tick();
        srst = 1'b0;

        // Reset values
        chk("rst_ctl1", 64'({ready1, idle1, done1, err1}), 64'b1100);
        chk("rst_axis1", 64'({s1_ready, m1_valid, m1_last, m1_data}),
            64'd0);
        chk("rst_ctl4", 64'({ready4, idle4, done4, err4}), 64'b1100);
        chk("rst_axis4", 64'({s4_ready, m4_valid, m4_last, m4_data}),
            64'd0);

        // Unity coefficient
        frame1("d255", 255, 4, '{8'd0, 8'd1, 8'd200, 8'd255},
               '{8'd0, 8'd1, 8'd200, 8'd255});
        // 127.5 rounds up, saturation above denom
        frame1("d128", 128, 4, '{8'd64, 8'd200, 8'd1, 8'd128},
               '{8'd128, 8'd255, 8'd2, 8'd255});
        // Truncated coefficient: 50 -> 127, 100 -> 255 (no overflow)
        frame1("d100", 100, 4, '{8'd99, 8'd50, 8'd100, 8'd101},
               '{8'd252, 8'd127, 8'd255, 8'd255});
        chk("err_clear", 64'(err1), 64'd0);
        // Divide by zero
        frame1("d0", 0, 2, '{8'd77, 8'd255, 8'd0, 8'd0},
               '{8'd0, 8'd0, 8'd0, 8'd0});
        chk("err_set", 64'(err1), 64'd1);

        // Single-beat frame, latency and sticky error
        q1.delete();
        d0 = done_cnt1;
        begin_frame1(1, 255);
        wait_ready1("single");
        s1_valid = 1'b1;
        s1_data = 8'd42;
        tick();
        s1_valid = 1'b0;
        chk("lat_c1_valid", 64'(m1_valid), 64'd0);
        tick();
        chk("lat_c2_beat", 64'({m1_valid, m1_last, done1, m1_data}),
            64'({3'b111, 8'd42}));
        tick();
        chk("single_idle", 64'(idle1), 64'd1);
        chk("single_done", 64'(done_cnt1), 64'(d0 + 1));
        chk("err_sticky", 64'(err1), 64'd1);

        // Late up_done, start during RUN ignored
        q1.delete();
        d0 = done_cnt1;
        fp1 = 15'd2;
        den1 = 8'd255;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            if (s1_ready !== 1'b0) bad++;
        end
        chk("noup_ready_low", 64'(bad), 64'd0);
        up1 = 1'b1;
        #1;
        chk("up_cycle_ready", 64'(s1_ready), 64'd0);
        tick();
        up1 = 1'b0;
        chk("capture_cycle_ready", 64'(s1_ready), 64'd0);
        tick();
        chk("run_ready", 64'(s1_ready), 64'd1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("start_in_run_ignored", 64'({idle1, s1_ready}), 64'b01);
        send1(8'd7);
        send1(8'd9);
        wait_done1("late", d0 + 1);
        chk("late_beats", 64'(q1.size()), 64'd2);
        chk("late_b0", 64'(q1[0]), 64'({1'b0, 8'd7}));
        chk("late_b1", 64'(q1[1]), 64'({1'b1, 8'd9}));

        // Reset with two beats in flight
        tick();
        m1_ready = 1'b0;
        q1.delete();
        d0 = done_cnt1;
        begin_frame1(4, 255);
        wait_ready1("abort");
        send1(8'd11);
        send1(8'd22);
        tick();
        chk("inflight_valid", 64'({m1_valid, s1_ready}), 64'b10);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("abort_ctl", 64'({m1_valid, ready1, idle1, err1}), 64'b0110);
        m1_ready = 1'b1;
        tick();
        tick();
        chk("abort_no_done", 64'(done_cnt1), 64'(d0));
        chk("abort_no_beats", 64'(q1.size()), 64'd0);
        frame1("post_rst", 128, 2, '{8'd64, 8'd1, 8'd0, 8'd0},
               '{8'd128, 8'd2, 8'd0, 8'd0});

        // LANES=4 with random back-pressure
        q4.delete();
        fp4 = 15'd8;
        den4 = 8'd200;
        start4 = 1'b1;
        tick4();
        start4 = 1'b0;
        up4 = 1'b1;
        tick4();
        up4 = 1'b0;
        s4_valid = 1'b1;
        s4_data = 32'hC896_640A;
        n = 0;
        while (!s4_ready && n < 200) begin
            tick4();
            n++;
        end
        tick4();
        s4_data = 32'hFFC9_0100;
        while (!s4_ready && n < 400) begin
            tick4();
            n++;
        end
        tick4();
        s4_valid = 1'b0;
        chk("l4_send_timeout", 64'(n < 400), 64'd1);
        n = 0;
        while (done_cnt4 < 1 && n < 200) begin
            tick4();
            n++;
        end
        m4_ready = 1'b1;
        repeat (4) tick();
        chk("l4_done_cnt", 64'(done_cnt4), 64'd1);
        chk("l4_beats", 64'(q4.size()), 64'd2);
        chk("l4_b0", 64'(q4[0]), 64'({1'b0, 32'hFFBF_7F0D}));
        chk("l4_b1", 64'(q4[1]), 64'({1'b1, 32'hFFFF_0100}));
        chk("l4_ready_after", 64'({s4_ready, idle4}), 64'b01);

        chk("stall_stable1", 64'(stab_err1), 64'd0);
        chk("stall_stable4", 64'(stab_err4), 64'd0);
        chk("done_tlast1", 64'(dl_err1), 64'd0);
        chk("done_tlast4", 64'(dl_err4), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
